// File: rtl/dm_mem_slave_pkg.sv
// Shared encodings for the data-memory port: stride codes, responder FSM states
// and the latched request payload.
package dm_mem_slave_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STRIDE_W = 2;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [STRIDE_W-1:0] {
    STRIDE_WORD = 2'd0,
    STRIDE_HALF = 2'd1,
    STRIDE_BYTE = 2'd2,
    STRIDE_RSVD = 2'd3
  } stride_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic            we;
    stride_e         stride;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc;
  } dm_req_t;

endpackage

// File: rtl/dm_mem_slave_if.sv
// Load/store request and response bundle between the core memory stage and the
// data-memory responder.
interface dm_mem_slave_if;
  import dm_mem_slave_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [STRIDE_W-1:0] req_stride;
  logic [XLEN-1:0]     req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic [XLEN-1:0]     req_pc;
  logic                resp_valid;
  logic [XLEN-1:0]     resp_rdata;
  logic                resp_err;

  modport master (
    output req_valid, req_we, req_stride, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_stride, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dm_mem_slave_lane_unit.sv
// Byte-lane logic: store byte-enable merge, load lane shift with zero extension,
// and alignment / reserved-stride / range error detection.
module dm_lane_unit
  import dm_mem_slave_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  stride_e         stride,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] old_word,
  output logic            err_c,
  output logic [XLEN-1:0] merged_c,
  output logic [XLEN-1:0] load_c
);

  logic [3:0]      be;
  logic [XLEN-1:0] wrep;
  logic [XLEN-1:0] shifted;
  logic            misalign;
  logic            range_err;

  assign shifted   = old_word >> {addr[1:0], 3'b000};
  assign range_err = (addr[XLEN-1:DEPTH_LOG2+2] != '0);
  assign err_c     = misalign | range_err;

  // Store data is replicated across lanes so the enable mask alone picks the target bytes.
  always_comb begin
    be       = 4'h0;
    wrep     = wdata;
    load_c   = '0;
    misalign = 1'b0;
    unique case (stride)
      STRIDE_WORD: begin
        be       = 4'hF;
        load_c   = old_word;
        misalign = (addr[1:0] != 2'b00);
      end
      STRIDE_HALF: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
        load_c   = {16'h0000, shifted[15:0]};
        misalign = addr[0];
      end
      STRIDE_BYTE: begin
        be     = 4'b0001 << addr[1:0];
        wrep   = {4{wdata[7:0]}};
        load_c = {24'h000000, shifted[7:0]};
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    merged_c = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged_c[8*b +: 8] = wrep[8*b +: 8];
    end
  end

endmodule

// File: rtl/dm_mem_slave.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, holds it
// LATENCY cycles, commits or reads the array and returns a one-cycle response.
module dm_mem_slave
  import dm_mem_slave_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 3
) (
  input  logic          clk,
  input  logic          reset,
  dm_mem_slave_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dm_req_t         req_q, req_d;
  logic            ready_q, ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  dm_req_t         live_req;
  dm_req_t         eff_req;
  logic [AW-1:0]   widx;
  logic [XLEN-1:0] old_word;
  logic            lane_err;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] load_data;
  logic            enter_resp;
  logic            commit_en;

  assign live_req = '{we:     bus.req_we,
                      stride: stride_e'(bus.req_stride),
                      addr:   bus.req_addr,
                      wdata:  bus.req_wdata,
                      pc:     bus.req_pc};

  // With LATENCY==1 the response is built on the accept edge, before the latch holds the request.
  assign eff_req  = (state_q == S_IDLE) ? live_req : req_q;
  assign widx     = eff_req.addr[DEPTH_LOG2+1:2];
  assign old_word = mem_q[widx];

  dm_lane_unit #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_lane (
    .stride   (eff_req.stride),
    .addr     (eff_req.addr),
    .wdata    (eff_req.wdata),
    .old_word (old_word),
    .err_c    (lane_err),
    .merged_c (merged),
    .load_c   (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          req_d = live_req;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    enter_resp   = (state_d == S_RESP);
    commit_en    = enter_resp && eff_req.we && !lane_err;
    ready_d      = (state_d == S_IDLE);
    resp_valid_d = enter_resp;
    resp_err_d   = enter_resp && lane_err;
    resp_rdata_d = (enter_resp && !eff_req.we && !lane_err) ? load_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[AW'(i)] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (commit_en) mem_q[widx] <= merged;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

`ifndef SYNTHESIS
  // Store trace for simulation logs.
  always_ff @(posedge clk) begin
    if (!reset && commit_en)
      $display("%d@%h: *%h <= %h", $time, eff_req.pc, {eff_req.addr[31:2], 2'b00}, merged);
  end
`endif

endmodule

// File: tb/tb_dm_mem_slave.sv
// Scoreboard bench for dm_mem_slave: expected responses are queued at accept and
// checked when resp_valid fires; latency and handshake spacing checked per task.
module tb_dm_mem_slave;

  localparam int unsigned LATENCY = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  bit   mon_en;
  int   pc_cnt;
  exp_t sb[$];

  dm_mem_slave_if bus ();

  dm_mem_slave #(
    .DEPTH_LOG2 (10),
    .LATENCY    (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response monitor: pops the scoreboard on every pulse, otherwise outputs must idle at zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.resp_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: got resp_valid=1 rdata=%h err=%b, required no response",
                   bus.resp_rdata, bus.resp_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_cmp++;
          if (bus.resp_rdata !== e.rdata) begin
            n_err++;
            $display("FAIL resp_rdata: got %h, required %h", bus.resp_rdata, e.rdata);
          end
          n_cmp++;
          if (bus.resp_err !== e.err) begin
            n_err++;
            $display("FAIL resp_err: got %b, required %b", bus.resp_err, e.err);
          end
        end
      end else begin
        n_cmp++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
          n_err++;
          $display("FAIL resp_idle: got valid=%b rdata=%h err=%b, required 0/00000000/0",
                   bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] stride, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input string tag);
    int guard;
    int lat;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_stride = stride;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_pc     = 32'h0000_0400 + 32'(pc_cnt * 4);
    pc_cnt++;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 50) begin
      n_err++;
      $display("FAIL %s_accept: req_ready stuck low, required high within 50 cycles", tag);
      bus.req_valid = 1'b0;
      return;
    end
    sb.push_back('{exp_rdata, exp_err});
    @(negedge clk);
    // Scramble inputs after accept: the request must already be latched.
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom());
    bus.req_stride = 2'($urandom());
    bus.req_addr   = $urandom();
    bus.req_wdata  = $urandom();
    bus.req_pc     = $urandom();
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != int'(LATENCY)) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", tag, lat, LATENCY);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready: cycle %0d got %b, required 1", i, bus.req_ready);
      end
    end
    send(1'b0, 2'd0, 32'h0, 32'h0, 32'h0000_0000, 1'b0, "reset_load0");
  endtask

  task automatic test_word();
    send(1'b1, 2'd0, 32'h10, 32'h1234_5678, 32'h0, 1'b0, "st_word");
    send(1'b0, 2'd0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, "ld_word");
  endtask

  task automatic test_lanes();
    send(1'b1, 2'd2, 32'h11, 32'hFFFF_FFAB, 32'h0, 1'b0, "st_byte");
    send(1'b1, 2'd1, 32'h12, 32'hFFFF_CDEF, 32'h0, 1'b0, "st_half");
    send(1'b0, 2'd0, 32'h10, 32'h0, 32'hCDEF_AB78, 1'b0, "ld_merged");
    send(1'b0, 2'd2, 32'h13, 32'h0, 32'h0000_00CD, 1'b0, "ld_byte");
    send(1'b0, 2'd1, 32'h10, 32'h0, 32'h0000_AB78, 1'b0, "ld_half");
    send(1'b0, 2'd2, 32'h11, 32'h0, 32'h0000_00AB, 1'b0, "ld_byte1");
    send(1'b1, 2'd0, 32'hFFC, 32'hDEAD_BEEF, 32'h0, 1'b0, "st_top");
    send(1'b0, 2'd0, 32'hFFC, 32'h0, 32'hDEAD_BEEF, 1'b0, "ld_top");
  endtask

  task automatic test_errors();
    send(1'b1, 2'd0, 32'h16, 32'h5555_5555, 32'h0, 1'b1, "err_st_word");
    send(1'b0, 2'd1, 32'h11, 32'h0, 32'h0, 1'b1, "err_ld_half");
    send(1'b0, 2'd3, 32'h10, 32'h0, 32'h0, 1'b1, "err_rsvd");
    send(1'b1, 2'd0, 32'h1000, 32'h7777_7777, 32'h0, 1'b1, "err_range");
    send(1'b0, 2'd0, 32'h1000, 32'h0, 32'h0, 1'b1, "err_range_ld");
    send(1'b0, 2'd0, 32'h10, 32'h0, 32'hCDEF_AB78, 1'b0, "err_unch10");
    send(1'b0, 2'd0, 32'h14, 32'h0, 32'h0000_0000, 1'b0, "err_unch14");
    send(1'b0, 2'd0, 32'h0, 32'h0, 32'h0000_0000, 1'b0, "err_unch00");
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    int acc_cyc [$];
    int cyc;
    int idx;
    int guard;
    addrs = '{32'h10, 32'hFFC, 32'h0};
    exps  = '{32'hCDEF_AB78, 32'hDEAD_BEEF, 32'h0};
    cyc = 0;
    idx = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_stride = 2'd0;
    bus.req_addr   = addrs[0];
    while (idx < 3 && cyc < 60) begin
      if (bus.req_ready === 1'b1) begin
        acc_cyc.push_back(cyc);
        sb.push_back('{exps[idx], 1'b0});
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (idx < 3) bus.req_addr = addrs[idx];
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (idx != 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d accepts, required 3", idx);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_cmp++;
      if (acc_cyc[i] - acc_cyc[i-1] != int'(LATENCY) + 1) begin
        n_err++;
        $display("FAIL b2b_spacing: accept %0d got %0d cycles apart, required %0d",
                 i, acc_cyc[i] - acc_cyc[i-1], LATENCY + 1);
      end
    end
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: got %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_stride = 2'd0;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hFFFF_FFFF;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_ready: got %b, required 1 before store", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_idle: got req_ready=%b, required 1 after reset", bus.req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (bus.resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rmid_noresp: cycle %0d got resp_valid=%b, required 0", i, bus.resp_valid);
      end
      @(negedge clk);
    end
    send(1'b0, 2'd0, 32'h20, 32'h0, 32'h0000_0000, 1'b0, "rmid_ld20");
    send(1'b0, 2'd0, 32'h10, 32'h0, 32'h0000_0000, 1'b0, "rmid_ld10");
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    mon_en         = 1'b0;
    pc_cnt         = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_stride = 2'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_pc     = 32'h0;

    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid();

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL final_drain: got %0d responses outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
